// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller producing HI/LO register writes.
// Multiplies complete after MULT_LAT cycles; divides use a 32-step restoring divider.
package muldiv_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    M_MULT  = 2'd0,
    M_MULTU = 2'd1,
    M_DIV   = 2'd2,
    M_DIVU  = 2'd3
  } multicycle_t;

  typedef struct packed {
    logic  valid;
    word_t data;
  } hilo_write_req;
endpackage

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  input  multicycle_t   req_op,
  input  word_t         req_a,
  input  word_t         req_b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output hilo_write_req hi_wr,
  output hilo_write_req lo_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  word_t      a_q, a_d;
  word_t      b_q, b_d;
  word_t      hi_q, hi_d;
  word_t      lo_q, lo_d;
  logic       mul_signed_q, mul_signed_d;
  logic       q_neg_q, q_neg_d;
  logic       r_neg_q, r_neg_d;

  logic        div_signed;
  word_t       a_mag, b_mag;
  logic [63:0] prod_s, prod_u, prod;
  logic [32:0] rem_sh, rem_sub;
  word_t       rem_new, quo_new;

  always_comb begin
    div_signed = (req_op == M_DIV);
    a_mag      = (div_signed && req_a[31]) ? -req_a : req_a;
    b_mag      = (div_signed && req_b[31]) ? -req_b : req_b;
  end

  always_comb begin
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod   = mul_signed_q ? prod_s : prod_u;
  end

  // Restoring step: hi_q holds the partial remainder, lo_q shifts dividend out / quotient in.
  always_comb begin
    rem_sh  = {hi_q, lo_q[31]};
    rem_sub = rem_sh - {1'b0, b_q};
    if (!rem_sub[32]) begin
      rem_new = rem_sub[31:0];
      quo_new = {lo_q[30:0], 1'b1};
    end else begin
      rem_new = rem_sh[31:0];
      quo_new = {lo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_signed_d = mul_signed_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (req_op == M_MULT || req_op == M_MULTU) begin
            state_d      = MUL;
            cnt_d        = 5'(MULT_LAT - 1);
            a_d          = req_a;
            b_d          = req_b;
            mul_signed_d = (req_op == M_MULT);
          end else if (req_b == '0) begin
            state_d = DONE;
            hi_d    = req_a;
            lo_d    = '1;
          end else begin
            state_d = DIV;
            cnt_d   = 5'd31;
            b_d     = b_mag;
            hi_d    = '0;
            lo_d    = a_mag;
            q_neg_d = div_signed && (req_a[31] ^ req_b[31]);
            r_neg_d = div_signed && req_a[31];
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          hi_d  = rem_new;
          lo_d  = quo_new;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == '0) begin
            state_d = DONE;
            hi_d    = r_neg_q ? -rem_new : rem_new;
            lo_d    = q_neg_q ? -quo_new : quo_new;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == MUL) || (state_q == DIV);
    done  = 1'b0;
    hi_wr = '0;
    lo_wr = '0;
    if (state_q == DONE && !flush) begin
      done  = 1'b1;
      hi_wr = '{valid: 1'b1, data: hi_q};
      lo_wr = '{valid: 1'b1, data: lo_q};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_signed_q <= mul_signed_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: latency, results, flush and reset behaviour.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  multicycle_t   req_op;
  word_t         req_a, req_b;
  logic          flush;
  logic          busy, done;
  hilo_write_req hi_wr, lo_wr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  muldiv_ctrl #(.MULT_LAT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi_wr     (hi_wr),
    .lo_wr     (lo_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
  task automatic issue(input multicycle_t op, input word_t a, input word_t b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = M_MULTU;
    req_a     = 32'h1234_5678;
    req_b     = 32'h0000_0000;
  endtask

  // Waits (bounded) for done; cyc is the cycle number in which done was seen.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 1;
    busy_ok = 1'b1;
    #1;
    while (!done && cyc <= 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input multicycle_t op, input word_t a, input word_t b,
                        input int exp_cyc, input word_t exp_hi, input word_t exp_lo);
    int cyc;
    bit busy_ok;
    issue(op, a, b);
    wait_done(cyc, busy_ok);
    check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_busy_while_running"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi_wr), {31'b0, 1'b1, exp_hi});
    check({tag, "_lo"}, 64'(lo_wr), {31'b0, 1'b1, exp_lo});
    @(negedge clk);
    #1;
    check({tag, "_done_single_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n_done;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = M_MULT;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi_wr", 64'(hi_wr), 64'd0);
    check("reset_lo_wr", 64'(lo_wr), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_op("mult_neg1x2",  M_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_max_x2", M_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_m3x5",    M_MULT,  32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_m7_2",     M_DIV,   32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",     M_DIV,   32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf",      M_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("divu_max_10",  M_DIVU,  32'hFFFF_FFFF, 32'd10, 33, 32'd5, 32'h1999_9999);
    run_op("divu_by0",     M_DIVU,  32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF);
    run_op("div_by0",      M_DIV,   32'hFFFF_FFF0, 32'd0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Flush in cycle 10 of a divide, then a request in cycle 11.
    issue(M_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_div_busy_c10", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_div_busy_c11", 64'(busy), 64'd0);
    check("flush_div_done_c11", 64'(done), 64'd0);
    run_op("divu_after_flush", M_DIVU, 32'd1000, 32'd7, 33, 32'd6, 32'd142);

    // Flush beats a request in IDLE.
    req_valid = 1'b1;
    req_op    = M_MULT;
    req_a     = 32'd3;
    req_b     = 32'd3;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    #1;
    check("flush_blocks_accept_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // Flush during DONE suppresses the write combinationally.
    issue(M_MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    #1;
    check("flush_done_pre_done", 64'(done), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_done_done", 64'(done), 64'd0);
    check("flush_done_hi_wr", 64'(hi_wr), 64'd0);
    check("flush_done_lo_wr", 64'(lo_wr), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_done_then_idle", 64'({busy, done}), 64'd0);

    // Asynchronous reset in cycle 2 of a multiply.
    issue(M_MULT, 32'd6, 32'd7);
    @(negedge clk);
    #1;
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi_wr", 64'(hi_wr), 64'd0);
    check("rst_mid_lo_wr", 64'(lo_wr), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (done) n_done++;
    end
    check("rst_mid_no_done_after", 64'(n_done), 64'd0);

    run_op("after_rst_mult", M_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);
    run_op("b2b_divu",       M_DIVU, 32'd50, 32'd8, 33, 32'd2, 32'd6);
    run_op("b2b_multu",      M_MULTU, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
